mine_placer: RTL

Sequences the 8-bit random-byte generator to populate a minesweeper board with exactly `MINES` distinct mines. The placer excludes an optional "safe" cell, normally the player's first click. It sits between the game FSM, which issues `start` and the safe cell, and the board state logic, which consumes `mine_map` once `done` is asserted. The placer samples the free-running random byte once per cycle and rejects out-of-range, duplicate and safe-cell candidates.

---
 rtl/mine_placer_if.sv | 25 ++
 rtl/mine_placer.sv | 118 +++++++++++
 2 files changed

// File: rtl/mine_placer_if.sv
// Handshake and result bundle between the game FSM and the mine placer.
interface mine_placer_if #(
    parameter int unsigned CELLS = 64
);
    logic             start;
    logic             safe_valid;
    logic [3:0]       safe_row;
    logic [3:0]       safe_col;
    logic [7:0]       rand_in;
    logic             busy;
    logic             done;
    logic [CELLS-1:0] mine_map;
    logic [7:0]       mine_count;
    logic [15:0]      attempts;

    modport master (
        output start, safe_valid, safe_row, safe_col, rand_in,
        input  busy, done, mine_map, mine_count, attempts
    );

    modport slave (
        input  start, safe_valid, safe_row, safe_col, rand_in,
        output busy, done, mine_map, mine_count, attempts
    );
endinterface

// File: rtl/mine_placer.sv
// Places exactly MINES distinct mines on a ROWS x COLS board from a free-running
// random byte, skipping an optional safe cell.
module mine_placer #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned MINES = 10
) (
    input  logic         clock,
    input  logic         reset,
    mine_placer_if.slave bus
);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IDXW  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDXW:0] CELLS_LIM = (IDXW + 1)'(CELLS);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

    state_t           state, state_nx;
    logic [CELLS-1:0] map_q, map_nx;
    logic [7:0]       count_q, count_nx;
    logic [15:0]      att_q, att_nx;
    logic [7:0]       safe_idx_q, safe_idx_nx;
    logic             safe_en_q, safe_en_nx;
    logic             busy_q, done_q;

    logic [IDXW-1:0]  cand_c;
    logic             in_range_c;
    logic             is_safe_c;
    logic             cand_ok_c;

    assign cand_c     = bus.rand_in[IDXW-1:0];
    assign in_range_c = ({1'b0, cand_c} < CELLS_LIM);
    assign is_safe_c  = safe_en_q && (8'(cand_c) == safe_idx_q);
    assign cand_ok_c  = in_range_c && !is_safe_c && !map_q[cand_c];

    if (IDXW < 8) begin : g_rand_hi
        logic rand_hi_unused;
        assign rand_hi_unused = ^bus.rand_in[7:IDXW];
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and datapath updates
    always_comb begin
        state_nx    = state;
        map_nx      = map_q;
        count_nx    = count_q;
        att_nx      = att_q;
        safe_idx_nx = safe_idx_q;
        safe_en_nx  = safe_en_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx    = CLEAR;
                    safe_idx_nx = 8'(bus.safe_row) * 8'(COLS) + 8'(bus.safe_col);
                    // An off-board safe cell must exclude nothing, even if the
                    // row-major index would alias onto a real cell.
                    safe_en_nx  = bus.safe_valid
                                  && ({1'b0, bus.safe_row} < 5'(ROWS))
                                  && ({1'b0, bus.safe_col} < 5'(COLS));
                end
            end
            CLEAR: begin
                map_nx   = '0;
                count_nx = '0;
                att_nx   = '0;
                state_nx = (MINES > 0) ? DRAW : DONE;
            end
            DRAW: begin
                if (att_q != 16'hFFFF) begin
                    att_nx = att_q + 16'd1;
                end
                if (cand_ok_c) begin
                    map_nx[cand_c] = 1'b1;
                    count_nx       = count_q + 8'd1;
                    if (count_nx == 8'(MINES)) begin
                        state_nx = DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered status decode
    always_ff @(posedge clock) begin
        if (!reset) begin
            map_q      <= '0;
            count_q    <= '0;
            att_q      <= '0;
            safe_idx_q <= '0;
            safe_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            map_q      <= map_nx;
            count_q    <= count_nx;
            att_q      <= att_nx;
            safe_idx_q <= safe_idx_nx;
            safe_en_q  <= safe_en_nx;
            busy_q     <= (state_nx == CLEAR) || (state_nx == DRAW);
            done_q     <= (state_nx == DONE);
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mine_map   = map_q;
    assign bus.mine_count = count_q;
    assign bus.attempts   = att_q;
endmodule
